// File: rtl/jk_bank_sched.sv
// Round-robin scheduled bank of JK cells: one requester at a time gets its
// HOLD/RESET/SET/TOGGLE command applied under its mask for rpt+1 cycles.
module jk_bank_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int CW    = 4,
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     cmd,
    input  logic [WIDTH*NREQ-1:0] mask,
    input  logic [CW*NREQ-1:0]    rpt,
    input  logic                  abort,
    output logic [NREQ-1:0]       gnt,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      q
);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    state_t           state;
    logic [OW-1:0]    ptr;
    logic [1:0]       cur_cmd;
    logic [WIDTH-1:0] cur_mask;
    logic [CW-1:0]    cnt;

    logic             sel_found;
    logic [OW-1:0]    sel_idx;
    logic [1:0]       sel_cmd;
    logic [WIDTH-1:0] sel_mask;
    logic [CW-1:0]    sel_rpt;
    logic [WIDTH-1:0] q_next;

    // Two passes give the wrapping search: first ptr..NREQ-1, then 0..ptr-1.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_cmd   = '0;
        sel_mask  = '0;
        sel_rpt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_found && req[i] && (i >= int'(ptr))) begin
                sel_found = 1'b1;
                sel_idx   = OW'(i);
                sel_cmd   = cmd[2*i +: 2];
                sel_mask  = mask[WIDTH*i +: WIDTH];
                sel_rpt   = rpt[CW*i +: CW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_found && req[i] && (i < int'(ptr))) begin
                sel_found = 1'b1;
                sel_idx   = OW'(i);
                sel_cmd   = cmd[2*i +: 2];
                sel_mask  = mask[WIDTH*i +: WIDTH];
                sel_rpt   = rpt[CW*i +: CW];
            end
        end
    end

    always_comb begin
        q_next = q;
        for (int b = 0; b < WIDTH; b++) begin
            if (cur_mask[b]) begin
                case (cur_cmd)
                    CMD_RESET:  q_next[b] = 1'b0;
                    CMD_SET:    q_next[b] = 1'b1;
                    CMD_TOGGLE: q_next[b] = ~q[b];
                    default:    q_next[b] = q[b];
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cur_cmd  <= '0;
            cur_mask <= '0;
            cnt      <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        cur_cmd  <= sel_cmd;
                        cur_mask <= sel_mask;
                        cnt      <= sel_rpt;
                        gnt      <= NREQ'(1) << sel_idx;
                        owner    <= sel_idx;
                        busy     <= 1'b1;
                        ptr      <= (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // Abort drops the burst without applying this cycle's command.
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        q <= q_next;
                        if (cnt == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
